// File: rtl/mdu.sv
// Multiply/divide unit: one-shot combinational result captured into shadow
// HI/LO at start, then a fixed-latency countdown before committing to HI/LO.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_op,
  input  logic        E_MDU_start,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  output logic [31:0] E_MDU_out,
  output logic        E_MDU_busy
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] LAT_MUL  = 4'd5;
  localparam logic [3:0] LAT_DIV  = 4'd10;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] shi_q, shi_d, slo_q, slo_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] prod_s, prod_u;
  logic        dvsr_nz;
  logic [31:0] dvsr_u, abs_a, abs_b, mag_q, mag_r;
  logic [31:0] uquo, urem, squo, srem;

  // Datapath: all four results computed from the current operands.
  // Signed divide works on magnitudes so the 0x80000000 / -1 case falls
  // out naturally (magnitude quotient 0x80000000 negates to itself).
  always_comb begin
    prod_s  = {{32{E_rs_data[31]}}, E_rs_data} * {{32{E_rt_data[31]}}, E_rt_data};
    prod_u  = {32'd0, E_rs_data} * {32'd0, E_rt_data};
    dvsr_nz = (E_rt_data != 32'd0);
    dvsr_u  = dvsr_nz ? E_rt_data : 32'd1;
    uquo    = E_rs_data / dvsr_u;
    urem    = E_rs_data % dvsr_u;
    abs_a   = E_rs_data[31] ? (~E_rs_data + 32'd1) : E_rs_data;
    abs_b   = E_rt_data[31] ? (~E_rt_data + 32'd1) : dvsr_u;
    mag_q   = abs_a / abs_b;
    mag_r   = abs_a % abs_b;
    squo    = (E_rs_data[31] ^ E_rt_data[31]) ? (~mag_q + 32'd1) : mag_q;
    srem    = E_rs_data[31] ? (~mag_r + 32'd1) : mag_r;
  end

  // Next state: countdown/commit while busy, otherwise accept start or mt.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    shi_d = shi_q;
    slo_d = slo_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = shi_q;
        lo_d = slo_q;
      end
    end else begin
      if (E_MDU_start) begin
        unique case (E_MDU_op)
          OP_MULT:  begin shi_d = prod_s[63:32]; slo_d = prod_s[31:0]; cnt_d = LAT_MUL; end
          OP_MULTU: begin shi_d = prod_u[63:32]; slo_d = prod_u[31:0]; cnt_d = LAT_MUL; end
          // Zero divisor: shadow mirrors committed so the commit is a no-op.
          OP_DIV:   begin
            shi_d = dvsr_nz ? srem : hi_q;
            slo_d = dvsr_nz ? squo : lo_q;
            cnt_d = LAT_DIV;
          end
          OP_DIVU:  begin
            shi_d = dvsr_nz ? urem : hi_q;
            slo_d = dvsr_nz ? uquo : lo_q;
            cnt_d = LAT_DIV;
          end
          default: ;
        endcase
      end
      if (E_MDU_op == OP_MTHI) hi_d = E_rs_data;
      if (E_MDU_op == OP_MTLO) lo_d = E_rs_data;
    end
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      shi_q <= '0;
      slo_q <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      shi_q <= shi_d;
      slo_q <= slo_d;
      cnt_q <= cnt_d;
    end
  end

  assign E_MDU_busy = (cnt_q != 4'd0);

  // Move-from read port on committed registers only.
  always_comb begin
    E_MDU_out = 32'd0;
    if (E_MDU_op == OP_MFHI) E_MDU_out = hi_q;
    if (E_MDU_op == OP_MFLO) E_MDU_out = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results and busy latencies.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDU_op;
  logic        E_MDU_start;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic [31:0] E_MDU_out;
  logic        E_MDU_busy;

  int n_chk = 0;
  int n_err = 0;

  mdu dut (
    .clk         (clk),
    .reset       (reset),
    .E_MDU_op    (E_MDU_op),
    .E_MDU_start (E_MDU_start),
    .E_rs_data   (E_rs_data),
    .E_rt_data   (E_rt_data),
    .E_MDU_out   (E_MDU_out),
    .E_MDU_busy  (E_MDU_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs and samples settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    E_MDU_op = 4'd0; E_MDU_start = 1'b0; E_rs_data = '0; E_rt_data = '0;
  endtask

  task automatic rd(input string tag, input logic [3:0] op, input logic [31:0] exp);
    E_MDU_op = op;
    #1;
    chk(tag, E_MDU_out, exp);
    E_MDU_op = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    E_MDU_op = op; E_rs_data = v;
    tick();
    idle();
  endtask

  // Issue a start and count post-edge cycles with busy high (bounded).
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int cyc);
    E_MDU_op = op; E_MDU_start = 1'b1; E_rs_data = a; E_rt_data = b;
    tick();
    idle();
    cyc = 0;
    while (E_MDU_busy && cyc < 30) begin
      cyc++;
      tick();
    end
  endtask

  int cyc;

  initial begin
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, E_MDU_busy}, 32'd0);
    rd("rst_hi", 4'd5, 32'd0);
    rd("rst_lo", 4'd6, 32'd0);

    // signed multiply -2 * 3
    run(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    chk("mult_busy", cyc, 32'd5);
    rd("mult_hi", 4'd5, 32'hFFFF_FFFF);
    rd("mult_lo", 4'd6, 32'hFFFF_FFFA);
    rd("op9_none", 4'd9, 32'd0);

    // unsigned multiply max * max
    run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_busy", cyc, 32'd5);
    rd("multu_hi", 4'd5, 32'hFFFF_FFFE);
    rd("multu_lo", 4'd6, 32'h0000_0001);

    // signed divide -7 / 2
    run(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_busy", cyc, 32'd10);
    rd("div_lo", 4'd6, 32'hFFFF_FFFD);
    rd("div_hi", 4'd5, 32'hFFFF_FFFF);

    // overflow divide
    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    rd("divov_lo", 4'd6, 32'h8000_0000);
    rd("divov_hi", 4'd5, 32'h0000_0000);

    // unsigned divide 100 / 7
    run(4'd4, 32'd100, 32'd7, cyc);
    rd("divu_lo", 4'd6, 32'd14);
    rd("divu_hi", 4'd5, 32'd2);

    // start with a non-arithmetic op is ignored
    E_MDU_op = 4'd5; E_MDU_start = 1'b1;
    tick();
    idle();
    chk("badop_busy", {31'd0, E_MDU_busy}, 32'd0);

    // divide by zero with mt and restart while busy
    mt(4'd7, 32'h0000_1234);
    mt(4'd8, 32'h0000_0000);
    rd("mthi", 4'd5, 32'h0000_1234);
    E_MDU_op = 4'd4; E_MDU_start = 1'b1; E_rs_data = 32'd99; E_rt_data = 32'd0;
    tick();
    idle();
    chk("dz_busy1", {31'd0, E_MDU_busy}, 32'd1);
    E_MDU_op = 4'd8; E_rs_data = 32'h0000_DEAD;
    tick();
    idle();
    E_MDU_op = 4'd1; E_MDU_start = 1'b1; E_rs_data = 32'd5; E_rt_data = 32'd5;
    tick();
    idle();
    cyc = 2;
    while (E_MDU_busy && cyc < 30) begin
      cyc++;
      tick();
    end
    chk("dz_busy", cyc, 32'd10);
    rd("dz_hi", 4'd5, 32'h0000_1234);
    rd("dz_lo", 4'd6, 32'h0000_0000);

    // mthi on the commit edge loses to the commit
    E_MDU_op = 4'd1; E_MDU_start = 1'b1; E_rs_data = 32'd2; E_rt_data = 32'd3;
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk("cm_last", {31'd0, E_MDU_busy}, 32'd1);
    E_MDU_op = 4'd7; E_rs_data = 32'h0000_AAAA;
    tick();
    idle();
    chk("cm_busy", {31'd0, E_MDU_busy}, 32'd0);
    rd("cm_hi", 4'd5, 32'd0);
    rd("cm_lo", 4'd6, 32'd6);

    // reset mid-operation
    mt(4'd7, 32'h55);
    mt(4'd8, 32'h55);
    rd("pre_lo", 4'd6, 32'h55);
    E_MDU_op = 4'd1; E_MDU_start = 1'b1; E_rs_data = 32'd7; E_rt_data = 32'd7;
    tick();
    idle();
    tick();
    tick();
    chk("mid_busy", {31'd0, E_MDU_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_busy", {31'd0, E_MDU_busy}, 32'd0);
    rd("ab_hi", 4'd5, 32'd0);
    rd("ab_lo", 4'd6, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("ab_busy2", {31'd0, E_MDU_busy}, 32'd0);
    rd("ab_hi2", 4'd5, 32'd0);
    rd("ab_lo2", 4'd6, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-high; sampled only on the `clk` rising edge.
REQ-003 The block SHALL have the port `E_MDU_op`, input, 4 bits: E-stage operation.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - Codes 9-15 are treated as none.
REQ-004 The block SHALL have the port `E_MDU_start`, input, 1 bit: one-cycle pulse when the E-stage instruction is mult/multu/div/divu.
REQ-005 The block SHALL have the port `E_rs_data`, input, 32 bits: forwarded rs operand; dividend, multiplicand, or mthi/mtlo data.
REQ-006 The block SHALL have the port `E_rt_data`, input, 32 bits: forwarded rt operand; divisor or multiplier.
REQ-007 The block SHALL have the port `E_MDU_out`, output, 32 bits: committed HI for mfhi, committed LO for mflo, else 0.
REQ-008 The block SHALL have the port `E_MDU_busy`, output, 1 bit: an operation is in progress; consumed by the hazard control unit for D-stage stall.

Function
REQ-009 The block SHALL hold internal state as follows:
  - 32-bit committed HI and LO registers.
  - 32-bit shadow HI and LO registers.
  - A 4-bit cycle counter `cnt`.
REQ-010 `E_MDU_busy` SHALL equal (`cnt` != 0) as a registered-state decode, with no combinational path from the inputs.
REQ-011 On a rising edge with `E_MDU_start`=1, `cnt`=0 and op 1-4, the block SHALL:
  - capture the operands;
  - compute the result into the shadow registers;
  - load `cnt` with 5 for mult/multu or 10 for div/divu.
REQ-012 The block SHALL produce these results:
  - mult: signed 64-bit product, HI = bits 63:32, LO = bits 31:0.
  - multu: the same as mult, unsigned.
REQ-013 The block SHALL produce these division results:
  - div: LO = signed quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - divu: the unsigned equivalent.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-014 For a divisor of 0 (div or divu), busy SHALL still run 10 cycles, and committed HI/LO SHALL remain unchanged at completion.
REQ-015 While `cnt` != 0, `cnt` SHALL decrement by 1 each edge; on the edge where `cnt` goes 1→0, the shadow registers SHALL be copied into committed HI/LO.
REQ-016 Latency SHALL be as follows, with start sampled at edge k:
  - busy=1 after edges k..k+N-1 (N=5 or 10 cycles).
  - busy=0 and the new HI/LO visible on `E_MDU_out` after edge k+N.
REQ-017 `E_MDU_start` while `cnt` != 0 SHALL be ignored: no reload, no operand capture.
REQ-018 `E_MDU_start` with op not in 1-4 SHALL be ignored.
REQ-019 mthi/mtlo SHALL write `E_rs_data` into committed HI/LO at the edge only when `cnt`=0; when `cnt` != 0 the write SHALL be ignored.
REQ-020 On the commit edge (`cnt` 1→0), a simultaneous mthi/mtlo SHALL be ignored, and the commit SHALL win.
REQ-021 mfhi/mflo SHALL read committed HI/LO combinationally. During busy they return pre-operation values, because the hazard unit prevents such reads.
REQ-022 The block SHALL contain no handshake other than start/busy. The hazard unit SHALL stall any D-stage mult/div/mf/mt instruction while (`E_MDU_start` | `E_MDU_busy`).

Reset
REQ-023 On a reset edge, HI, LO, the shadow registers and `cnt` SHALL become 0; `E_MDU_busy`=0; `E_MDU_out`=0.
REQ-024 Reset SHALL take priority over start, mt and commit on the same edge.
REQ-025 Reset during an operation SHALL abort it and discard its result.
REQ-026 Between reset and the first edge, outputs SHALL be don't-care; after the first reset edge all outputs SHALL be defined.

Verification
REQ-027 The bench SHALL cover a signed multiply:
  - stimulus: reset; mult with rs=0xFFFFFFFE (-2), rt=3, start pulse;
  - response: busy high exactly 5 cycles; then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFA.
REQ-028 The bench SHALL cover an unsigned multiply:
  - stimulus: multu with rs=0xFFFFFFFF, rt=0xFFFFFFFF;
  - response: after 5 cycles, HI=0xFFFFFFFE and LO=0x00000001.
REQ-029 The bench SHALL cover a signed divide and the overflow case:
  - div with rs=-7 (0xFFFFFFF9), rt=2 → busy exactly 10 cycles; then LO=0xFFFFFFFD and HI=0xFFFFFFFF;
  - div with 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
REQ-030 The bench SHALL cover divide by zero, mt while busy, and a second start while busy:
  - stimulus: mthi 0x1234; then divu with rt=0; mtlo issued during busy; a second start during busy;
  - response: HI stays 0x1234 and LO stays 0; busy is exactly 10 cycles with no extension.
REQ-031 The bench SHALL cover reset mid-operation:
  - stimulus: HI=LO=0x55 via mt; mult started; reset asserted at cycle 3 of busy;
  - response: busy=0, HI=LO=0 next cycle, and no later commit occurs.
